color_marker_detector: RTL and testbench

- Produces the interesting-pixel stream consumed by the corner/object recognition block.
- Scans the incoming active-video RGB pixel stream and tracks pixel coordinates.
- Classifies each pixel against four marker colour classes and emits a one-cycle flag with coordinates and class for every match.
- Holds frame_flag high from end of frame until the next frame starts, so the downstream block can run its averaging and sqrt computation during blanking.

---
 rtl/color_marker_if.sv | 45 ++++
 rtl/color_marker_detector.sv | 205 ++++++++++++++++++++
 tb/tb_color_marker_detector.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_marker_if.sv
// color_marker_if
//   Bundles the pixel input stream and the interesting-pixel output stream of
//   color_marker_detector.
//
//   Handshake: there is no ready. pix_data is consumed on every rising clk
//   edge where pix_valid is high, one pixel per clock, with no backpressure.
//   interesting_flag is a one-cycle pulse that qualifies color,
//   interesting_x and interesting_y. Those three hold their last flagged
//   values while the flag is low.
//
//   Signals:
//     frame_start      source -> detector  one-cycle start-of-frame pulse
//     pix_valid        source -> detector  pix_data valid this cycle
//     pix_data[23:0]   source -> detector  {R, G, B}
//     color[1:0]       detector -> sink    class of the flagged pixel
//     interesting_x    detector -> sink    x of the flagged pixel
//     interesting_y    detector -> sink    y of the flagged pixel
//     interesting_flag detector -> sink    one pulse per matching pixel
//     frame_flag       detector -> sink    high from end of frame to next start
//     dbg_state[1:0]   detector -> sink    FSM state (0 IDLE, 1 ACTIVE, 2 DRAIN, 3 BLANK)
//
//   Modports: master is the pixel source / result sink; slave is the detector.
interface color_marker_if;
  logic        frame_start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [1:0]  color;
  logic [9:0]  interesting_x;
  logic [8:0]  interesting_y;
  logic        interesting_flag;
  logic        frame_flag;
  logic [1:0]  dbg_state;

  modport master (
    output frame_start, pix_valid, pix_data,
    input  color, interesting_x, interesting_y, interesting_flag, frame_flag,
           dbg_state
  );

  modport slave (
    input  frame_start, pix_valid, pix_data,
    output color, interesting_x, interesting_y, interesting_flag, frame_flag,
           dbg_state
  );
endinterface

// File: rtl/color_marker_detector.sv
// color_marker_detector
//   Scans an active-video RGB pixel stream, tracks pixel coordinates and emits
//   a one-cycle flag (with x, y and colour class) for every pixel that matches
//   one of four marker colours: 0 red, 1 green, 2 blue, 3 yellow. frame_flag is
//   held high from the end of a frame until the next frame_start, so the
//   downstream block can work during blanking.
//
//   Pipeline: stage 1 registers the pixel and its coordinates. Stage 2
//   classifies the pixel and registers the outputs. A pixel therefore appears
//   on the outputs exactly two cycles after its pix_valid.
//
//   Optional build macro COLOR_RUN_FILTER_EN: when it is defined, a pixel is
//   flagged only when it is the RUN_LEN-th or a later pixel of a run of
//   same-class pixels within one line.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high
//     bus    color_marker_if.slave (pixel stream in, flags out, dbg_state)
module color_marker_detector #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int T_HI     = 160,
  parameter int T_LO     = 96
`ifdef COLOR_RUN_FILTER_EN
  , parameter int RUN_LEN = 3
`endif
) (
  input logic           clk,
  input logic           reset,
  color_marker_if.slave bus
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);
  localparam logic [7:0] HI     = 8'(T_HI);
  localparam logic [7:0] LO     = 8'(T_LO);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    BLANK  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] x_cnt, x_nxt, cur_x;
  logic [8:0] y_cnt, y_nxt, cur_y;
  logic       drain_cnt, drain_nxt;
  logic       accept;

  // A frame_start coincident with pix_valid makes that pixel (0,0), and it
  // is accepted from any state.
  always_comb begin
    accept    = bus.pix_valid && (bus.frame_start || state == ACTIVE);
    cur_x     = bus.frame_start ? 10'd0 : x_cnt;
    cur_y     = bus.frame_start ? 9'd0  : y_cnt;
    state_nxt = state;
    x_nxt     = cur_x;
    y_nxt     = cur_y;
    drain_nxt = drain_cnt;
    if (accept) begin
      if (cur_x == X_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (cur_y == Y_LAST) ? 9'd0 : cur_y + 9'd1;
      end else begin
        x_nxt = cur_x + 10'd1;
      end
    end
    case (state)
      IDLE:   if (bus.frame_start) state_nxt = ACTIVE;
      ACTIVE: if (!bus.frame_start && accept && cur_x == X_LAST && cur_y == Y_LAST) begin
                state_nxt = DRAIN;
                drain_nxt = 1'b0;
              end
      // Two drain cycles let the last pixel leave the pipeline before
      // frame_flag rises.
      DRAIN:  if (bus.frame_start) state_nxt = ACTIVE;
              else if (drain_cnt) state_nxt = BLANK;
              else drain_nxt = 1'b1;
      BLANK:  if (bus.frame_start) state_nxt = ACTIVE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      x_cnt     <= 10'd0;
      y_cnt     <= 9'd0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Stage 1: register the accepted pixel and its coordinates.
  logic        s1_valid;
  logic [23:0] s1_data;
  logic [9:0]  s1_x;
  logic [8:0]  s1_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= 24'd0;
      s1_x     <= 10'd0;
      s1_y     <= 9'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= bus.pix_data;
        s1_x    <= cur_x;
        s1_y    <= cur_y;
      end
    end
  end

  // Stage 2: classify. The four classes are mutually exclusive by construction.
  logic [7:0] r, g, b;
  logic       match;
  logic [1:0] cls;
  logic       pass;

  always_comb begin
    r     = s1_data[23:16];
    g     = s1_data[15:8];
    b     = s1_data[7:0];
    match = 1'b1;
    cls   = 2'd0;
    if      (r >= HI && g <  LO && b <  LO) cls = 2'd0;
    else if (g >= HI && r <  LO && b <  LO) cls = 2'd1;
    else if (b >= HI && r <  LO && g <  LO) cls = 2'd2;
    else if (r >= HI && g >= HI && b <  LO) cls = 2'd3;
    else match = 1'b0;
  end

`ifdef COLOR_RUN_FILTER_EN
  localparam int            RW      = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);

  logic [RW-1:0] run_cnt, run_nxt;
  logic [1:0]    run_cls;

  // The run count saturates at RUN_LEN. A gap in pix_valid leaves it untouched.
  always_comb begin
    run_nxt = run_cnt;
    if (s1_valid) begin
      if (!match)
        run_nxt = '0;
      else if (s1_x == 10'd0 || bus.frame_start || cls != run_cls)
        run_nxt = RW'(1);
      else if (run_cnt != RUN_MAX)
        run_nxt = run_cnt + RW'(1);
    end else if (bus.frame_start) begin
      run_nxt = '0;
    end
    pass = match && (run_nxt >= RUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
      run_cls <= 2'd0;
    end else begin
      run_cnt <= run_nxt;
      if (s1_valid && match) run_cls <= cls;
    end
  end
`else
  always_comb pass = match;
`endif

  logic       flag_q;
  logic [1:0] color_q;
  logic [9:0] x_q;
  logic [8:0] y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      color_q <= 2'd0;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
    end else begin
      flag_q <= s1_valid && pass;
      if (s1_valid && pass) begin
        color_q <= cls;
        x_q     <= s1_x;
        y_q     <= s1_y;
      end
    end
  end

  assign bus.interesting_flag = flag_q;
  assign bus.color            = color_q;
  assign bus.interesting_x    = x_q;
  assign bus.interesting_y    = y_q;
  assign bus.frame_flag       = (state == BLANK);
  assign bus.dbg_state        = state;

endmodule

// File: tb/tb_color_marker_detector.sv
// tb_color_marker_detector
//   Directed bench for color_marker_detector. V_ACTIVE is shortened to 16
//   lines so that a full frame stays small; H_ACTIVE keeps its 640 default so
//   the x-wrap coordinates match real video.
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   at that same point. A pixel driven in cycle k is therefore visible on
//   the outputs in cycle k+2.
module tb_color_marker_detector;
  localparam int H = 640;
  localparam int V = 16;

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] RED    = 24'hC83C28;
  localparam logic [23:0] YELLOW = 24'hC8C828;
  localparam logic [23:0] GREEN  = 24'h20F020;
  localparam logic [23:0] BLUE   = 24'h1010FF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  color_marker_if bus_if();

  color_marker_detector #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard: every observed flag as {color, y, x}.
  int          flag_cnt = 0;
  logic [20:0] flag_q[$];
  logic [20:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset && bus_if.interesting_flag === 1'b1) begin
      flag_cnt++;
      flag_q.push_back({bus_if.color, bus_if.interesting_y, bus_if.interesting_x});
    end
  end

  // ---------------- clock/reset and driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic pv, input logic [23:0] d);
    bus_if.frame_start = fs;
    bus_if.pix_valid   = pv;
    bus_if.pix_data    = d;
  endtask

  task automatic send_black(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, BLACK);
      step();
    end
    drive(1'b0, 1'b0, BLACK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, BLACK);
    repeat (3) step();
    checks++; if (bus_if.interesting_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", bus_if.interesting_flag); end
    checks++; if (bus_if.color !== 2'd0) begin failures++; $display("FAIL reset_color got=%0d exp=0", bus_if.color); end
    checks++; if (bus_if.interesting_x !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", bus_if.interesting_x); end
    checks++; if (bus_if.interesting_y !== 9'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", bus_if.interesting_y); end
    checks++; if (bus_if.frame_flag !== 1'b0) begin failures++; $display("FAIL reset_frame_flag got=%b exp=0", bus_if.frame_flag); end
    checks++; if (bus_if.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus_if.dbg_state); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_blank_frame();
    int base;
    base = flag_cnt;
    drive(1'b1, 1'b0, BLACK);
    step();
    send_black(H * V);
    // Now one cycle after the last pix_valid.
    checks++; if (bus_if.frame_flag !== 1'b0) begin failures++; $display("FAIL ff_plus1 got=%b exp=0", bus_if.frame_flag); end
    step();
    checks++; if (bus_if.frame_flag !== 1'b0) begin failures++; $display("FAIL ff_plus2 got=%b exp=0", bus_if.frame_flag); end
    step();
    checks++; if (bus_if.frame_flag !== 1'b1) begin failures++; $display("FAIL ff_plus3 got=%b exp=1", bus_if.frame_flag); end
    checks++; if (bus_if.dbg_state !== 2'd3) begin failures++; $display("FAIL blank_state got=%0d exp=3", bus_if.dbg_state); end
    checks++; if (flag_cnt !== base) begin failures++; $display("FAIL black_frame_flags got=%0d exp=%0d", flag_cnt, base); end
    repeat (4) step();
    drive(1'b1, 1'b0, BLACK);
    checks++; if (bus_if.frame_flag !== 1'b1) begin failures++; $display("FAIL ff_at_start got=%b exp=1", bus_if.frame_flag); end
    step();
    drive(1'b0, 1'b0, BLACK);
    checks++; if (bus_if.frame_flag !== 1'b0) begin failures++; $display("FAIL ff_after_start got=%b exp=0", bus_if.frame_flag); end
    checks++; if (bus_if.dbg_state !== 2'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", bus_if.dbg_state); end
  endtask

  task automatic test_classify();
    logic [23:0] tbl_d[9];
    logic        tbl_m[9];
    logic [1:0]  tbl_c[9];
    tbl_d = '{24'hA05F5F, 24'h9F5F5F, 24'hA06000, GREEN, BLUE,
              24'hFFFF00, 24'hA0A05F, 24'hFFFF60, BLACK};
    tbl_m = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    // The frame is at (0,0); advance to (5,7).
    send_black(7 * H + 5);
    drive(1'b0, 1'b1, RED);
    step();
    drive(1'b0, 1'b1, YELLOW);
    checks++; if (bus_if.interesting_flag !== 1'b0) begin failures++; $display("FAIL red_early got=%b exp=0", bus_if.interesting_flag); end
    step();
    drive(1'b0, 1'b1, 24'h80A040);
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd0, 10'd5, 9'd7})
      begin failures++; $display("FAIL red_5_7 got=f%b c%0d x%0d y%0d exp=f1 c0 x5 y7", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    step();
    drive(1'b0, 1'b0, BLACK);
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd3, 10'd6, 9'd7})
      begin failures++; $display("FAIL yellow_6_7 got=f%b c%0d x%0d y%0d exp=f1 c3 x6 y7", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b0, 2'd3, 10'd6, 9'd7})
      begin failures++; $display("FAIL nomatch_hold got=f%b c%0d x%0d y%0d exp=f0 c3 x6 y7", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    // Threshold edges, one pixel every other cycle, starting at x=8.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, tbl_d[i]);
      step();
      drive(1'b0, 1'b0, BLACK);
      step();
      checks++; if (bus_if.interesting_flag !== tbl_m[i]) begin failures++; $display("FAIL tbl%0d_flag got=%b exp=%b", i, bus_if.interesting_flag, tbl_m[i]); end
      if (tbl_m[i]) begin
        checks++; if ({bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {tbl_c[i], 10'(8 + i), 9'd7})
          begin failures++; $display("FAIL tbl%0d_out got=c%0d x%0d y%0d exp=c%0d x%0d y7", i, bus_if.color, bus_if.interesting_x, bus_if.interesting_y, tbl_c[i], 8 + i); end
      end
    end
  endtask

  task automatic test_wrap();
    // Position is (17,7); advance to (639,7).
    send_black(622);
    drive(1'b0, 1'b1, GREEN);
    step();
    drive(1'b0, 1'b0, BLACK);
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd1, 10'd639, 9'd7})
      begin failures++; $display("FAIL wrap_639 got=f%b c%0d x%0d y%0d exp=f1 c1 x639 y7", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    step();
    checks++; if (bus_if.interesting_flag !== 1'b0) begin failures++; $display("FAIL wrap_pulse got=%b exp=0", bus_if.interesting_flag); end
    step();
    drive(1'b0, 1'b1, GREEN);
    step();
    drive(1'b0, 1'b0, BLACK);
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd1, 10'd0, 9'd8})
      begin failures++; $display("FAIL wrap_0 got=f%b c%0d x%0d y%0d exp=f1 c1 x0 y8", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
  endtask

  task automatic test_short_frame();
    drive(1'b1, 1'b0, BLACK);
    step();
    send_black(999);
    drive(1'b0, 1'b1, RED);          // pixel index 999 -> (359,1)
    step();
    drive(1'b1, 1'b1, GREEN);        // new frame, this pixel is (0,0)
    step();
    drive(1'b0, 1'b1, BLUE);         // (1,0)
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd0, 10'd359, 9'd1})
      begin failures++; $display("FAIL inflight got=f%b c%0d x%0d y%0d exp=f1 c0 x359 y1", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    step();
    drive(1'b0, 1'b0, BLACK);
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd1, 10'd0, 9'd0})
      begin failures++; $display("FAIL restart_0_0 got=f%b c%0d x%0d y%0d exp=f1 c1 x0 y0", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd2, 10'd1, 9'd0})
      begin failures++; $display("FAIL restart_1_0 got=f%b c%0d x%0d y%0d exp=f1 c2 x1 y0", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
    checks++; if (bus_if.frame_flag !== 1'b0) begin failures++; $display("FAIL short_ff got=%b exp=0", bus_if.frame_flag); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    drive(1'b0, 1'b1, RED);
    step();
    drive(1'b0, 1'b0, BLACK);
    reset = 1'b1;
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y, bus_if.frame_flag} !== {1'b0, 2'd0, 10'd0, 9'd0, 1'b0})
      begin failures++; $display("FAIL midreset_out got=f%b c%0d x%0d y%0d ff%b exp=all 0", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y, bus_if.frame_flag); end
    checks++; if (bus_if.dbg_state !== 2'd0) begin failures++; $display("FAIL midreset_state got=%0d exp=0", bus_if.dbg_state); end
    reset = 1'b0;
    step();
    base = flag_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, RED);
      step();
    end
    drive(1'b0, 1'b0, BLACK);
    repeat (3) step();
    checks++; if (flag_cnt !== base) begin failures++; $display("FAIL idle_drop got=%0d exp=%0d", flag_cnt, base); end
    checks++; if (bus_if.dbg_state !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", bus_if.dbg_state); end
    drive(1'b1, 1'b1, YELLOW);
    step();
    drive(1'b0, 1'b0, BLACK);
    step();
    checks++; if ({bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y} !== {1'b1, 2'd3, 10'd0, 9'd0})
      begin failures++; $display("FAIL idle_start got=f%b c%0d x%0d y%0d exp=f1 c3 x0 y0", bus_if.interesting_flag, bus_if.color, bus_if.interesting_x, bus_if.interesting_y); end
  endtask

  task automatic test_run_filter();
    int first;
    drive(1'b1, 1'b0, BLACK);
    step();
    // Part 1: blue run x=10..14 on line 2.
    send_black(2 * H + 10);
    flag_q.delete();
    exp_q.delete();
`ifdef COLOR_RUN_FILTER_EN
    first = 12;
`else
    first = 10;
`endif
    for (int x = first; x <= 14; x++) exp_q.push_back({2'd2, 9'd2, 10'(x)});
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, BLUE);
      step();
    end
    drive(1'b0, 1'b0, BLACK);
    repeat (3) step();
    checks++; if (flag_q.size() !== exp_q.size()) begin failures++; $display("FAIL run_count got=%0d exp=%0d", flag_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < flag_q.size(); i++) begin
      checks++; if (flag_q[i] !== exp_q[i]) begin failures++; $display("FAIL run_entry%0d got=%h exp=%h", i, flag_q[i], exp_q[i]); end
    end
    // Part 2: blue at x=638, 639 and x=0 of the next line.
    send_black(623);
    flag_q.delete();
    exp_q.delete();
`ifndef COLOR_RUN_FILTER_EN
    exp_q.push_back({2'd2, 9'd2, 10'd638});
    exp_q.push_back({2'd2, 9'd2, 10'd639});
    exp_q.push_back({2'd2, 9'd3, 10'd0});
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, BLUE);
      step();
    end
    drive(1'b0, 1'b0, BLACK);
    repeat (3) step();
    checks++; if (flag_q.size() !== exp_q.size()) begin failures++; $display("FAIL wraprun_count got=%0d exp=%0d", flag_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < flag_q.size(); i++) begin
      checks++; if (flag_q[i] !== exp_q[i]) begin failures++; $display("FAIL wraprun_entry%0d got=%h exp=%h", i, flag_q[i], exp_q[i]); end
    end
    // Part 3: green at x=1,2,3 of line 3 with pix_valid gaps in between.
    flag_q.delete();
    exp_q.delete();
`ifndef COLOR_RUN_FILTER_EN
    exp_q.push_back({2'd1, 9'd3, 10'd1});
    exp_q.push_back({2'd1, 9'd3, 10'd2});
`endif
    exp_q.push_back({2'd1, 9'd3, 10'd3});
    drive(1'b0, 1'b1, GREEN);
    step();
    drive(1'b0, 1'b0, BLACK);
    repeat (2) step();
    drive(1'b0, 1'b1, GREEN);
    step();
    drive(1'b0, 1'b0, BLACK);
    step();
    drive(1'b0, 1'b1, GREEN);
    step();
    drive(1'b0, 1'b0, BLACK);
    repeat (3) step();
    checks++; if (flag_q.size() !== exp_q.size()) begin failures++; $display("FAIL gaprun_count got=%0d exp=%0d", flag_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < flag_q.size(); i++) begin
      checks++; if (flag_q[i] !== exp_q[i]) begin failures++; $display("FAIL gaprun_entry%0d got=%h exp=%h", i, flag_q[i], exp_q[i]); end
    end
  endtask

  // Every wait above is a fixed cycle count; this bounds the run as a whole.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    drive(1'b0, 1'b0, BLACK);
    test_reset();
    test_blank_frame();
    test_classify();
    test_wrap();
    test_short_frame();
    test_reset_mid_frame();
    test_run_filter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
